// File: rtl/iob_cache_memory_mb.sv
// iob_cache_memory_mb: set-associative write-back/write-allocate cache store with its own miss FSM.
// Optional feature macro IOB_CACHE_MEMORY_MB_STATS_EN adds saturating hit/miss/write-back counters.
module iob_cache_memory_mb #(
   parameter int FE_ADDR_W     = 24,
   parameter int FE_DATA_W     = 32,
   parameter int NLINES_W      = 4,
   parameter int NWAYS_W       = 1,
   parameter int WORD_OFFSET_W = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_i,
   input  logic [FE_ADDR_W-1:0]   addr_i,
   input  logic [FE_DATA_W-1:0]   wdata_i,
   input  logic [FE_DATA_W/8-1:0] wstrb_i,
   output logic [FE_DATA_W-1:0]   rdata_o,
   output logic                   ack_o,
   input  logic                   invalidate_i,
   output logic                   busy_o,
   output logic                   be_req_o,
   output logic                   be_we_o,
   output logic [FE_ADDR_W-1:0]   be_addr_o,
   output logic [FE_DATA_W-1:0]   be_wdata_o,
   input  logic [FE_DATA_W-1:0]   be_rdata_i,
   input  logic                   be_ack_i
`ifdef IOB_CACHE_MEMORY_MB_STATS_EN
   ,
   output logic [31:0]            hit_cnt_o,
   output logic [31:0]            miss_cnt_o,
   output logic [31:0]            wback_cnt_o
`endif
);

   localparam int NWAYS  = 2**NWAYS_W;
   localparam int NLINES = 2**NLINES_W;
   localparam int NBEATS = 2**WORD_OFFSET_W;
   localparam int NBYTES = FE_DATA_W/8;
   localparam int BYTE_W = $clog2(NBYTES);
   localparam int AW     = FE_ADDR_W - BYTE_W;
   localparam int TAG_W  = AW - NLINES_W - WORD_OFFSET_W;
   localparam int WAY_W  = (NWAYS_W > 0) ? NWAYS_W : 1;

   typedef enum logic [1:0] {IDLE, LOOKUP, WBACK, REFILL} state_t;

   function automatic logic [FE_DATA_W-1:0] merge_bytes(input logic [FE_DATA_W-1:0] old_w,
                                                        input logic [FE_DATA_W-1:0] new_w,
                                                        input logic [NBYTES-1:0]    strb);
      logic [FE_DATA_W-1:0] res;
      res = old_w;
      for (int b = 0; b < NBYTES; b++) begin
         res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      end
      return res;
   endfunction

   state_t                   state_r, state_nxt_s;
   logic [AW-1:0]            addr_r;
   logic [FE_DATA_W-1:0]     wdata_r;
   logic [NBYTES-1:0]        wstrb_r;
   logic [WORD_OFFSET_W-1:0] beat_r, beat_nxt_s;
   logic [WAY_W-1:0]         victim_r;
   logic                     inv_pend_r;
   logic [NWAYS-1:0][NLINES-1:0] valid_r, dirty_r;
   logic [WAY_W-1:0]         rr_r [NLINES];
   logic [TAG_W-1:0]         tag_mem_r [NWAYS][NLINES];
   logic [FE_DATA_W-1:0]     data_mem_r [NWAYS][NLINES][NBEATS];
   logic                     ack_r, be_req_r, be_we_r;
   logic [FE_DATA_W-1:0]     rdata_r, be_wdata_r;
   logic [FE_ADDR_W-1:0]     be_addr_r;

   logic [TAG_W-1:0]         tag_s, be_tag_s;
   logic [NLINES_W-1:0]      idx_s;
   logic [WORD_OFFSET_W-1:0] word_s;
   logic [NWAYS-1:0]         hit_vec_s;
   logic                     hit_s, is_write_s, be_hs_s, last_beat_s, inv_now_s;
   logic [WAY_W-1:0]         hit_way_s, victim_s, way_sel_s, rr_nxt_s;
   logic [FE_DATA_W-1:0]     hit_word_s, merged_s;
   logic                     accept_s, inv_apply_s, lookup_hit_s, lookup_miss_s;
   logic                     wb_done_s, refill_wr_s, refill_done_s;
   logic                     be_req_nxt_s, be_we_nxt_s;

   assign tag_s       = addr_r[AW-1 -: TAG_W];
   assign idx_s       = addr_r[WORD_OFFSET_W +: NLINES_W];
   assign word_s      = addr_r[WORD_OFFSET_W-1:0];
   assign is_write_s  = |wstrb_r;
   assign be_hs_s     = be_req_r && be_ack_i;
   assign last_beat_s = (beat_r == {WORD_OFFSET_W{1'b1}});
   assign inv_now_s   = invalidate_i || inv_pend_r;
   assign hit_s       = |hit_vec_s;
   assign hit_word_s  = data_mem_r[hit_way_s][idx_s][word_s];
   assign merged_s    = merge_bytes(hit_word_s, wdata_r, wstrb_r);
   assign rr_nxt_s    = (rr_r[idx_s] == WAY_W'(NWAYS-1)) ? {WAY_W{1'b0}} : rr_r[idx_s] + WAY_W'(1);

   // Tag compare per way; descending scan so the lowest hit way and lowest invalid way win
   always_comb begin
      hit_vec_s = {NWAYS{1'b0}};
      hit_way_s = {WAY_W{1'b0}};
      victim_s  = rr_r[idx_s];
      for (int w = NWAYS-1; w >= 0; w--) begin
         hit_vec_s[w] = valid_r[w][idx_s] && (tag_mem_r[w][idx_s] == tag_s);
         hit_way_s    = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
         victim_s     = !valid_r[w][idx_s] ? WAY_W'(w) : victim_s;
      end
   end

   // Next-state and control strobes
   always_comb begin
      state_nxt_s   = state_r;
      beat_nxt_s    = beat_r;
      be_req_nxt_s  = 1'b0;
      be_we_nxt_s   = 1'b0;
      be_tag_s      = tag_s;
      way_sel_s     = victim_r;
      accept_s      = 1'b0;
      inv_apply_s   = 1'b0;
      lookup_hit_s  = 1'b0;
      lookup_miss_s = 1'b0;
      wb_done_s     = 1'b0;
      refill_wr_s   = 1'b0;
      refill_done_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (inv_now_s) begin
               inv_apply_s = 1'b1;
            end else if (req_i && !ack_r) begin
               accept_s    = 1'b1;
               state_nxt_s = LOOKUP;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOOKUP: begin
            way_sel_s = victim_s;
            if (hit_s) begin
               lookup_hit_s = 1'b1;
               state_nxt_s  = IDLE;
            end else begin
               lookup_miss_s = 1'b1;
               be_req_nxt_s  = 1'b1;
               beat_nxt_s    = {WORD_OFFSET_W{1'b0}};
               if (dirty_r[victim_s][idx_s]) begin
                  state_nxt_s = WBACK;
                  be_we_nxt_s = 1'b1;
                  be_tag_s    = tag_mem_r[victim_s][idx_s];
               end else begin
                  state_nxt_s = REFILL;
               end
            end
         end
         WBACK: begin
            be_req_nxt_s = 1'b1;
            be_we_nxt_s  = 1'b1;
            be_tag_s     = tag_mem_r[victim_r][idx_s];
            if (be_hs_s) begin
               beat_nxt_s = beat_r + WORD_OFFSET_W'(1);
               if (last_beat_s) begin
                  wb_done_s   = 1'b1;
                  state_nxt_s = REFILL;
                  be_we_nxt_s = 1'b0;
                  be_tag_s    = tag_s;
               end else begin
                  state_nxt_s = WBACK;
               end
            end else begin
               state_nxt_s = WBACK;
            end
         end
         REFILL: begin
            be_req_nxt_s = 1'b1;
            if (be_hs_s) begin
               refill_wr_s = 1'b1;
               beat_nxt_s  = beat_r + WORD_OFFSET_W'(1);
               if (last_beat_s) begin
                  refill_done_s = 1'b1;
                  be_req_nxt_s  = 1'b0;
                  state_nxt_s   = LOOKUP;
               end else begin
                  state_nxt_s = REFILL;
               end
            end else begin
               state_nxt_s = REFILL;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_r <= IDLE;
      else       state_r <= state_nxt_s;
   end

   // Request capture, beat counter, victim choice and deferred invalidate
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_r     <= {AW{1'b0}};
         wdata_r    <= {FE_DATA_W{1'b0}};
         wstrb_r    <= {NBYTES{1'b0}};
         beat_r     <= {WORD_OFFSET_W{1'b0}};
         victim_r   <= {WAY_W{1'b0}};
         inv_pend_r <= 1'b0;
      end else begin
         if (accept_s) begin
            addr_r  <= addr_i[FE_ADDR_W-1:BYTE_W];
            wdata_r <= wdata_i;
            wstrb_r <= wstrb_i;
         end
         beat_r <= beat_nxt_s;
         if (lookup_miss_s) victim_r <= victim_s;
         if (inv_apply_s)       inv_pend_r <= 1'b0;
         else if (invalidate_i) inv_pend_r <= 1'b1;
      end
   end

   // Line state: valid, dirty and per-set round-robin pointer
   always_ff @(posedge clk_i) begin
      if (rst_i || inv_apply_s) begin
         valid_r <= '0;
         dirty_r <= '0;
         if (rst_i) begin
            for (int l = 0; l < NLINES; l++) rr_r[l] <= {WAY_W{1'b0}};
         end
      end else if (lookup_hit_s && is_write_s) begin
         dirty_r[hit_way_s][idx_s] <= 1'b1;
      end else if (wb_done_s) begin
         dirty_r[victim_r][idx_s] <= 1'b0;
      end else if (refill_done_s) begin
         valid_r[victim_r][idx_s] <= 1'b1;
         dirty_r[victim_r][idx_s] <= 1'b0;
         rr_r[idx_s]              <= rr_nxt_s;
      end
   end

   // Tag and data storage; contents are meaningless until the valid bit is set
   always_ff @(posedge clk_i) begin
      if (lookup_hit_s && is_write_s) data_mem_r[hit_way_s][idx_s][word_s] <= merged_s;
      if (refill_wr_s)   data_mem_r[victim_r][idx_s][beat_r] <= be_rdata_i;
      if (refill_done_s) tag_mem_r[victim_r][idx_s] <= tag_s;
   end

   // Registered front-end and back-end outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_r      <= 1'b0;
         rdata_r    <= {FE_DATA_W{1'b0}};
         be_req_r   <= 1'b0;
         be_we_r    <= 1'b0;
         be_addr_r  <= {FE_ADDR_W{1'b0}};
         be_wdata_r <= {FE_DATA_W{1'b0}};
      end else begin
         ack_r    <= lookup_hit_s;
         if (lookup_hit_s) rdata_r <= hit_word_s;
         be_req_r <= be_req_nxt_s;
         be_we_r  <= be_we_nxt_s;
         be_addr_r <= be_req_nxt_s ? {be_tag_s, idx_s, beat_nxt_s, {BYTE_W{1'b0}}} : {FE_ADDR_W{1'b0}};
         be_wdata_r <= be_we_nxt_s ? data_mem_r[way_sel_s][idx_s][beat_nxt_s] : {FE_DATA_W{1'b0}};
      end
   end

   assign ack_o      = ack_r;
   assign rdata_o    = rdata_r;
   assign busy_o     = (state_r != IDLE);
   assign be_req_o   = be_req_r;
   assign be_we_o    = be_we_r;
   assign be_addr_o  = be_addr_r;
   assign be_wdata_o = be_wdata_r;

`ifdef IOB_CACHE_MEMORY_MB_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic        retry_r;
   logic [31:0] hit_cnt_r, miss_cnt_r, wback_cnt_r;

   // Marks the LOOKUP that re-runs an access after its refill
   always_ff @(posedge clk_i) begin
      if (rst_i)                 retry_r <= 1'b0;
      else if (refill_done_s)    retry_r <= 1'b1;
      else if (state_r == LOOKUP) retry_r <= 1'b0;
   end

   // Saturating event counters
   always_ff @(posedge clk_i) begin
      if (rst_i || inv_apply_s) begin
         hit_cnt_r   <= 32'd0;
         miss_cnt_r  <= 32'd0;
         wback_cnt_r <= 32'd0;
      end else begin
         if (lookup_hit_s && !retry_r) hit_cnt_r <= sat_inc(hit_cnt_r);
         if (lookup_miss_s)            miss_cnt_r <= sat_inc(miss_cnt_r);
         if (wb_done_s)                wback_cnt_r <= sat_inc(wback_cnt_r);
      end
   end

   assign hit_cnt_o   = hit_cnt_r;
   assign miss_cnt_o  = miss_cnt_r;
   assign wback_cnt_o = wback_cnt_r;
`endif

endmodule

// File: tb/tb_iob_cache_memory_mb.sv
// Directed self-checking bench for iob_cache_memory_mb with a reactive back-end memory model.
module tb_iob_cache_memory_mb;

   logic        clk = 1'b0;
   logic        rst_i, req_i, invalidate_i, be_ack_i;
   logic [23:0] addr_i;
   logic [31:0] wdata_i, be_rdata_i;
   logic [3:0]  wstrb_i;
   logic [31:0] rdata_o, be_wdata_o;
   logic        ack_o, busy_o, be_req_o, be_we_o;
   logic [23:0] be_addr_o;
`ifdef IOB_CACHE_MEMORY_MB_STATS_EN
   logic [31:0] hit_cnt_o, miss_cnt_o, wback_cnt_o;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [23:0] log_addr[$];
   logic        log_we[$];
   logic [31:0] log_wd[$];

   always #5 clk = ~clk;

   iob_cache_memory_mb dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .wstrb_i(wstrb_i), .rdata_o(rdata_o), .ack_o(ack_o), .invalidate_i(invalidate_i),
      .busy_o(busy_o), .be_req_o(be_req_o), .be_we_o(be_we_o), .be_addr_o(be_addr_o),
      .be_wdata_o(be_wdata_o), .be_rdata_i(be_rdata_i), .be_ack_i(be_ack_i)
`ifdef IOB_CACHE_MEMORY_MB_STATS_EN
      , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .wback_cnt_o(wback_cnt_o)
`endif
   );

   // Backing memory content: every word carries its own address
   function automatic logic [31:0] bmem(input logic [23:0] a);
      return {8'hA5, a};
   endfunction

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic int count_beats(input logic we);
      int n = 0;
      foreach (log_we[i]) if (log_we[i] == we) n++;
      return n;
   endfunction

   task automatic check_line(input string tag, input int start, input logic we, input logic [23:0] base);
      logic [23:0] a;
      logic        w;
      for (int i = 0; i < 4; i++) begin
         a = (start + i < log_addr.size()) ? log_addr[start+i] : 24'hFFFFFF;
         w = (start + i < log_we.size()) ? log_we[start+i] : ~we;
         check_val($sformatf("%s_addr%0d", tag, i), {8'h00, a}, {8'h00, base + 24'(4*i)});
         check_val($sformatf("%s_we%0d", tag, i), {31'd0, w}, {31'd0, we});
      end
   endtask

   // One front-end access; answers back-end beats every other cycle and logs them
   task automatic do_access(input logic [23:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            input int inv_at, input int abort_beat,
                            output logic [31:0] rd, output int lat, output logic done,
                            output logic aborted, output logic busy_at_inv);
      int nref;
      log_addr.delete(); log_we.delete(); log_wd.delete();
      nref = 0; rd = 32'd0; lat = 0; done = 1'b0; aborted = 1'b0; busy_at_inv = 1'b0;
      req_i = 1'b1; addr_i = a; wdata_i = wd; wstrb_i = ws;
      for (int t = 1; t <= 300 && !done && !aborted; t++) begin
         @(negedge clk);
         invalidate_i = (t == inv_at);
         if (t == inv_at) busy_at_inv = busy_o;
         if (ack_o) begin
            rd = rdata_o; lat = t; done = 1'b1; req_i = 1'b0;
         end
         if (be_ack_i) begin
            be_ack_i = 1'b0;
         end else if (be_req_o) begin
            be_ack_i   = 1'b1;
            be_rdata_i = bmem(be_addr_o);
            log_addr.push_back(be_addr_o);
            log_we.push_back(be_we_o);
            log_wd.push_back(be_wdata_o);
            if (!be_we_o) begin
               nref++;
               if (nref == abort_beat) begin
                  rst_i = 1'b1; req_i = 1'b0; aborted = 1'b1;
               end
            end
         end
      end
      invalidate_i = 1'b0;
      if (!aborted) begin
         req_i = 1'b0;
         @(negedge clk);
         be_ack_i = 1'b0;
      end
   endtask

   logic [31:0] rd, hi48, wd;
   int          lat;
   logic        done, ab, bz;
   logic [31:0] line_exp [4];

   initial begin
      rst_i = 1'b1; req_i = 1'b0; invalidate_i = 1'b0; be_ack_i = 1'b0;
      addr_i = 24'd0; wdata_i = 32'd0; wstrb_i = 4'd0; be_rdata_i = 32'd0;
      repeat (3) @(negedge clk);
      check_val("rst_ack", {31'd0, ack_o}, 32'd0);
      check_val("rst_busy", {31'd0, busy_o}, 32'd0);
      check_val("rst_be_req", {31'd0, be_req_o}, 32'd0);
      check_val("rst_rdata", rdata_o, 32'd0);
      check_val("rst_be_addr", {8'h00, be_addr_o}, 32'd0);
      rst_i = 1'b0;
      @(negedge clk);

      // Cold miss: clean refill of set 4, way 0
      do_access(24'h000040, 32'd0, 4'h0, 0, 0, rd, lat, done, ab, bz);
      check_val("rd40_done", {31'd0, done}, 32'd1);
      check_val("rd40_data", rd, bmem(24'h000040));
      check_val("rd40_nwb", 32'(count_beats(1'b1)), 32'd0);
      check_val("rd40_nref", 32'(count_beats(1'b0)), 32'd4);
      check_line("rd40_ref", 0, 1'b0, 24'h000040);
`ifdef IOB_CACHE_MEMORY_MB_STATS_EN
      check_val("miss_cnt1", miss_cnt_o, 32'd1);
`endif

      // Hit in the same line
      do_access(24'h000044, 32'd0, 4'h0, 0, 0, rd, lat, done, ab, bz);
      check_val("rd44_lat", 32'(lat), 32'd2);
      check_val("rd44_nbeats", 32'(log_addr.size()), 32'd0);
      check_val("rd44_data", rd, bmem(24'h000044));
`ifdef IOB_CACHE_MEMORY_MB_STATS_EN
      check_val("hit_cnt1", hit_cnt_o, 32'd1);
`endif

      // Partial write hit returns the old word, then the merged word reads back
      do_access(24'h000048, 32'hDEADBEEF, 4'h3, 0, 0, rd, lat, done, ab, bz);
      check_val("wr48_lat", 32'(lat), 32'd2);
      check_val("wr48_old", rd, bmem(24'h000048));
      check_val("wr48_nbeats", 32'(log_addr.size()), 32'd0);
      do_access(24'h000048, 32'd0, 4'h0, 0, 0, rd, lat, done, ab, bz);
      hi48 = bmem(24'h000048);
      check_val("rd48_merged", rd, {hi48[31:16], 16'hBEEF});

      // Second tag fills the invalid way 1
      do_access(24'h010040, 32'd0, 4'h0, 0, 0, rd, lat, done, ab, bz);
      check_val("rd10040_nwb", 32'(count_beats(1'b1)), 32'd0);
      check_line("rd10040_ref", 0, 1'b0, 24'h010040);
      check_val("rd10040_data", rd, bmem(24'h010040));

      // Third tag: round-robin picks dirty way 0, written back before refill
      do_access(24'h020040, 32'd0, 4'h0, 0, 0, rd, lat, done, ab, bz);
      line_exp[0] = bmem(24'h000040);
      line_exp[1] = bmem(24'h000044);
      line_exp[2] = {hi48[31:16], 16'hBEEF};
      line_exp[3] = bmem(24'h00004C);
      check_val("ev_nwb", 32'(count_beats(1'b1)), 32'd4);
      check_line("ev_wb", 0, 1'b1, 24'h000040);
      for (int i = 0; i < 4; i++) begin
         wd = (i < log_wd.size()) ? log_wd[i] : 32'hFFFF_FFFF;
         check_val($sformatf("ev_wdata%0d", i), wd, line_exp[i]);
      end
      check_line("ev_ref", 4, 1'b0, 24'h020040);
      check_val("ev_data", rd, bmem(24'h020040));
`ifdef IOB_CACHE_MEMORY_MB_STATS_EN
      check_val("wback_cnt1", wback_cnt_o, 32'd1);
`endif

      // Pointer flipped: next victim is clean way 1, no write-back
      do_access(24'h030040, 32'd0, 4'h0, 0, 0, rd, lat, done, ab, bz);
      check_val("rr_nwb", 32'(count_beats(1'b1)), 32'd0);
      check_val("rr_nref", 32'(count_beats(1'b0)), 32'd4);
      check_val("rr_data", rd, bmem(24'h030040));
      do_access(24'h020044, 32'd0, 4'h0, 0, 0, rd, lat, done, ab, bz);
      check_val("rd20044_lat", 32'(lat), 32'd2);
      check_val("rd20044_nbeats", 32'(log_addr.size()), 32'd0);
      check_val("rd20044_data", rd, bmem(24'h020044));

      // Reset on the third refill beat aborts the line
      do_access(24'h000050, 32'd0, 4'h0, 0, 3, rd, lat, done, ab, bz);
      check_val("abort_hit", {31'd0, ab}, 32'd1);
      @(negedge clk);
      check_val("abort_be_req", {31'd0, be_req_o}, 32'd0);
      check_val("abort_busy", {31'd0, busy_o}, 32'd0);
      rst_i = 1'b0; be_ack_i = 1'b0;
      @(negedge clk);
      do_access(24'h000050, 32'd0, 4'h0, 0, 0, rd, lat, done, ab, bz);
      check_val("rd50_nref", 32'(count_beats(1'b0)), 32'd4);
      check_line("rd50_ref", 0, 1'b0, 24'h000050);
      check_val("rd50_data", rd, bmem(24'h000050));

      // Invalidate during a busy access discards dirty data
      do_access(24'h000050, 32'h11223344, 4'hF, 0, 0, rd, lat, done, ab, bz);
      check_val("wr50_lat", 32'(lat), 32'd2);
      do_access(24'h000060, 32'd0, 4'h0, 3, 0, rd, lat, done, ab, bz);
      check_val("inv_busy", {31'd0, bz}, 32'd1);
      check_val("inv_done", {31'd0, done}, 32'd1);
      check_val("inv_data", rd, bmem(24'h000060));
      do_access(24'h000050, 32'd0, 4'h0, 0, 0, rd, lat, done, ab, bz);
      check_val("postinv50_nwb", 32'(count_beats(1'b1)), 32'd0);
      check_val("postinv50_nref", 32'(count_beats(1'b0)), 32'd4);
      check_val("postinv50_data", rd, bmem(24'h000050));
      do_access(24'h000060, 32'd0, 4'h0, 0, 0, rd, lat, done, ab, bz);
      check_val("postinv60_nref", 32'(count_beats(1'b0)), 32'd4);
      check_val("postinv60_done", {31'd0, done}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
